// File: rtl/geofence_pkg.sv
// Shared FSM encoding and sizing helpers for the geofence point-in-convex-polygon block.
package geofence_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SORT,
        CHECK,
        DONE
    } state_t;

    // Signed width of a 2-D cross product of CW-bit unsigned coordinate differences.
    function automatic int cross_w(input int cw);
        return 2 * cw + 3;
    endfunction

    // Bubble sort of NV-1 vertices: NV-2 passes of NV-2 adjacent compares.
    function automatic int sort_cycles(input int nv);
        return (nv - 2) * (nv - 2);
    endfunction

endpackage

// File: rtl/geofence_n_if.sv
// Frame-word input handshake and one-cycle result strobe of the geofence block.
interface geofence_n_if #(
    parameter int CW = 10
);
    logic          in_valid;
    logic [CW-1:0] X;
    logic [CW-1:0] Y;
    logic          ready;
    logic          valid;
    logic          is_inside;
    logic          on_edge;

    modport master (output in_valid, X, Y, input ready, valid, is_inside, on_edge);
    modport slave  (input in_valid, X, Y, output ready, valid, is_inside, on_edge);
endinterface

// File: rtl/geofence_cross.sv
// Combinational cross((a - r), (b - r)) at full precision; zero latency, no flow control.
module geofence_cross
    import geofence_pkg::*;
#(
    parameter int CW = 10
) (
    input  logic [CW-1:0]                a_x,
    input  logic [CW-1:0]                a_y,
    input  logic [CW-1:0]                b_x,
    input  logic [CW-1:0]                b_y,
    input  logic [CW-1:0]                r_x,
    input  logic [CW-1:0]                r_y,
    output logic signed [cross_w(CW)-1:0] z
);
    localparam int DW = CW + 1;
    localparam int PW = 2 * CW + 2;
    localparam int XW = cross_w(CW);

    logic signed [DW-1:0] dax, day, dbx, dby;
    logic signed [PW-1:0] p1, p2;

    assign dax = $signed({1'b0, a_x}) - $signed({1'b0, r_x});
    assign day = $signed({1'b0, a_y}) - $signed({1'b0, r_y});
    assign dbx = $signed({1'b0, b_x}) - $signed({1'b0, r_x});
    assign dby = $signed({1'b0, b_y}) - $signed({1'b0, r_y});

    assign p1 = PW'(dax) * PW'(dby);
    assign p2 = PW'(day) * PW'(dbx);
    assign z  = XW'(p1) - XW'(p2);
endmodule

// File: rtl/geofence_n.sv
// Loads P plus NV convex-polygon vertices, bubble-sorts them CCW about V0, then tests P against every edge.
// Result strobes (NV-2)^2+NV+1 cycles after the last vertex; ready drops from SORT until the result has been shown.
module geofence_n
    import geofence_pkg::*;
#(
    parameter int CW          = 10,
    parameter int NV          = 6,
    parameter bit EDGE_INSIDE = 1'b1
) (
    input logic         clk,
    input logic         reset,
    geofence_n_if.slave bus
);
    localparam int XW   = cross_w(CW);
    localparam int IW   = $clog2(NV);
    localparam int CNTW = 6;
    localparam logic [CNTW-1:0] LAST_VTX  = CNTW'(NV - 1);
    localparam logic [CNTW-1:0] LAST_SORT = CNTW'(sort_cycles(NV) - 1);
    localparam logic [IW-1:0]   LAST_J    = IW'(NV - 2);
    localparam logic [IW-1:0]   LAST_K    = IW'(NV - 1);

    state_t               state, state_nxt;
    logic [CNTW-1:0]      cnt;
    logic [IW-1:0]        j, jn, k, kn;
    logic                 neg, zero, acc;
    logic [CW-1:0]        px, py;
    logic [CW-1:0]        vx [NV];
    logic [CW-1:0]        vy [NV];
    logic [CW-1:0]        ax, ay, bx, by, rx, ry;
    logic signed [XW-1:0] cr;
    logic                 cr_neg, cr_zero;

    assign acc     = bus.in_valid && bus.ready;
    assign k       = cnt[IW-1:0];
    assign kn      = (k == LAST_K) ? '0 : k + IW'(1);
    assign jn      = j + IW'(1);
    assign cr_neg  = cr[XW-1];
    assign cr_zero = (cr == '0);

    // One shared cross unit: SORT compares Vj/Vj+1 about V0, CHECK tests P against edge Vk->Vk+1.
    always_comb begin
        ax = vx[kn];
        ay = vy[kn];
        bx = px;
        by = py;
        rx = vx[k];
        ry = vy[k];
        if (state == SORT) begin
            ax = vx[j];
            ay = vy[j];
            bx = vx[jn];
            by = vy[jn];
            rx = vx[0];
            ry = vy[0];
        end
    end

    geofence_cross #(.CW(CW)) u_cross (
        .a_x (ax),
        .a_y (ay),
        .b_x (bx),
        .b_y (by),
        .r_x (rx),
        .r_y (ry),
        .z   (cr)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.ready     = 1'b0;
        bus.valid     = 1'b0;
        bus.is_inside = 1'b0;
        bus.on_edge   = 1'b0;
        case (state)
            IDLE: begin
                bus.ready = 1'b1;
                if (bus.in_valid) state_nxt = LOAD;
            end
            LOAD: begin
                bus.ready = 1'b1;
                if (bus.in_valid && cnt == LAST_VTX) state_nxt = SORT;
            end
            SORT:  if (cnt == LAST_SORT) state_nxt = CHECK;
            CHECK: if (cnt == LAST_VTX) state_nxt = DONE;
            DONE: begin
                bus.valid     = 1'b1;
                bus.is_inside = !neg && (EDGE_INSIDE || !zero);
                bus.on_edge   = zero && !neg;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            j    <= '0;
            neg  <= 1'b0;
            zero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (acc) cnt <= '0;
                LOAD: if (acc) begin
                    cnt <= (cnt == LAST_VTX) ? '0 : cnt + CNTW'(1);
                    j   <= IW'(1);
                end
                SORT: begin
                    j <= (j == LAST_J) ? IW'(1) : jn;
                    if (cnt == LAST_SORT) begin
                        cnt  <= '0;
                        neg  <= 1'b0;
                        zero <= 1'b0;
                    end else begin
                        cnt <= cnt + CNTW'(1);
                    end
                end
                CHECK: begin
                    if (cr_neg)  neg  <= 1'b1;
                    if (cr_zero) zero <= 1'b1;
                    cnt <= (cnt == LAST_VTX) ? '0 : cnt + CNTW'(1);
                end
                default: ;
            endcase
        end
    end

    // Coordinate storage needs no reset: every frame rewrites it before use.
    always_ff @(posedge clk) begin
        if (state == IDLE && acc) begin
            px <= bus.X;
            py <= bus.Y;
        end
        if (state == LOAD && acc) begin
            vx[k] <= bus.X;
            vy[k] <= bus.Y;
        end
        if (state == SORT && cr_neg) begin
            vx[j]  <= vx[jn];
            vy[j]  <= vy[jn];
            vx[jn] <= vx[j];
            vy[jn] <= vy[j];
        end
    end
endmodule
